// File: rtl/left_shifter_seq_if.sv
// Purpose : request/response bundle for the sequential 64-bit left shifter.
// Ports   : request side  in_valid/in_ready, a (64), b (6), word (1)
//           response side out_valid/out_ready, s (64)
// master = requester/consumer, slave = the shifter itself.
interface left_shifter_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [5:0]  b;
    logic        word;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;

    modport master (
        output in_valid, a, b, word, out_ready,
        input  in_ready, out_valid, s
    );

    modport slave (
        input  in_valid, a, b, word, out_ready,
        output in_ready, out_valid, s
    );
endinterface

// File: rtl/left_shifter_seq.sv
// Purpose : 64-bit logical left shift (SLL / SLLW) done as a 6-stage barrel, one stage per clock.
// Latency : accept edge + 6 SHIFT edges; out_valid rises on the 7th edge counting the accept edge.
// Backpr. : one request in flight; in_ready low until the result is taken; DONE holds s until out_ready.
// Ports   : clk, reset (async, active-high), io_bus (slave modport of left_shifter_seq_if).
module left_shifter_seq (
    input  logic                    clk,
    input  logic                    reset,
    left_shifter_seq_if.slave       io_bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] LAST_STAGE = 3'd5;

    logic [1:0]  r_state;
    logic [2:0]  r_stage;
    logic [63:0] r_work;
    logic [5:0]  r_b;
    logic        r_word;

    logic [5:0]  w_stage_amt;
    logic [63:0] w_shifted;
    logic [63:0] w_sllw;
    logic [63:0] w_result;
    logic        w_accept;
    logic        w_release;

    // Stage k moves the word by 2^k when bit k of the amount is set, so six
    // stages cover every amount 0..63 in a fixed number of cycles.
    assign w_stage_amt = 6'd1 << r_stage;
    assign w_shifted   = r_b[r_stage] ? (r_work << w_stage_amt) : r_work;

    // Bits above 31 of the working register never reach the low word during
    // a left shift, so the word result is just the low half sign-extended.
    assign w_sllw   = {{32{r_work[31]}}, r_work[31:0]};
    assign w_result = r_word ? w_sllw : r_work;

    assign w_accept  = (r_state == ST_IDLE) && io_bus.in_valid;
    assign w_release = (r_state == ST_DONE) && io_bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_stage <= 3'd0;
            r_work  <= 64'd0;
            r_b     <= 6'd0;
            r_word  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= io_bus.a;
                        // Word mode only honours a 5-bit amount.
                        r_b     <= {io_bus.b[5] & ~io_bus.word, io_bus.b[4:0]};
                        r_word  <= io_bus.word;
                        r_stage <= 3'd0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_shifted;
                    if (r_stage == LAST_STAGE) begin
                        r_stage <= 3'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_stage <= r_stage + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_work  <= 64'd0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_stage <= 3'd0;
                    r_work  <= 64'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == ST_IDLE);
    assign io_bus.out_valid = (r_state == ST_DONE);
    // Gate the result so nothing stale is visible outside DONE.
    assign io_bus.s         = (r_state == ST_DONE) ? w_result : 64'd0;

    // Only three encodings are ever legal.
    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        r_state != 2'd3);

    // The stage counter is only non-zero while shifting.
    a_stage_idle: assert property (@(posedge clk) disable iff (reset)
        (r_state != ST_SHIFT) |-> (r_stage == 3'd0));

endmodule

// File: tb/tb_left_shifter_seq.sv
// Purpose : self-checking bench for left_shifter_seq; a driver issues requests and
//           pushes expected results, a negedge monitor pops them on each output handshake.
// Ports   : none (top-level bench).
module tb_left_shifter_seq;

    logic clk;
    logic reset;

    left_shifter_seq_if bus ();

    left_shifter_seq dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: shifting by n is multiplying by 2^n modulo 2^64; word mode
    // works on a 5-bit amount and keeps the signed low 32 bits.
    function automatic logic [63:0] ref_model(input logic [63:0] a, input int unsigned amt, input bit w);
        logic [63:0] prod;
        logic [31:0] lo;
        int unsigned n;
        n    = w ? (amt % 32) : (amt % 64);
        prod = a * (64'd1 << n);
        lo   = prod[31:0];
        if (w) return {{32{lo[31]}}, lo};
        return prod;
    endfunction

    // Scoreboard monitor: every output handshake consumes one expected value.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got result %h expected no result", bus.s);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("scoreboard_s", bus.s, mon_exp);
            end
        end
    end

    task automatic do_req(input logic [63:0] a, input logic [5:0] b, input bit w,
                          input logic [63:0] exp, input int delay);
        int cnt;
        logic [63:0] held;
        chk("pre_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.a        = a;
        bus.b        = b;
        bus.word     = w;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        // Scramble inputs after accept: they must not affect the result.
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = 6'($urandom);
        bus.word     = 1'($urandom);
        chk("accepted_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("shift_s_zero", bus.s, 64'd0);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            bus.out_ready = 1'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        bus.out_ready = 1'b0;
        chk("latency_edges", 64'(cnt), 64'd6);
        if (bus.out_valid) begin
            held = bus.s;
            for (int i = 0; i < delay; i++) begin
                @(posedge clk); #1;
                chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
                chk("hold_s_stable", bus.s, held);
                chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'($urandom);
            chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
            chk("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("release_s_zero", bus.s, 64'd0);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        logic        rw;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 64'd0;
        bus.b         = 6'd0;
        bus.word      = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_s", bus.s, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(64'h0000_0000_0000_0001, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 10);
        do_req(64'hDEAD_BEEF_0123_4567, 6'd0,  1'b0, 64'hDEAD_BEEF_0123_4567, 1);
        do_req(64'h1234_5678_4000_0001, 6'd1,  1'b1, 64'hFFFF_FFFF_8000_0002, 0);
        do_req(64'h0000_0000_0000_0001, 6'd33, 1'b1, 64'h0000_0000_0000_0002, 2);

        // Abort at stage 3: no result may appear for this request.
        bus.a        = {$urandom, $urandom};
        bus.b        = 6'd45;
        bus.word     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort_s", bus.s, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(64'd3, 6'd4, 1'b0, 64'h30, 1);

        for (int b = 0; b < 64; b++) begin
            ra = {$urandom, $urandom};
            rw = 1'($urandom);
            do_req(ra, 6'(b), rw, ref_model(ra, b, rw), int'($urandom_range(0, 4)));
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
